// File: rtl/button_press_decoder.sv
// Turns a debounced button level into single-cycle short/long/double press
// pulses plus a hold level. All timing runs off an internal millisecond tick.
module button_press_decoder #(
    parameter int unsigned ClkFreq     = 100_000_000,
    parameter int unsigned LongPressMs = 1000,
    parameter int unsigned DoubleGapMs = 250
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_level_i,
    output logic short_press_o,
    output logic long_press_o,
    output logic double_press_o,
    output logic hold_o
);

    localparam int unsigned CYC_PER_MS = ClkFreq / 1000;
    localparam int unsigned PRESC_MAX  = CYC_PER_MS - 1;
    localparam int          PRESC_W    = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
    localparam int unsigned MS_MAX     = (LongPressMs > DoubleGapMs) ? LongPressMs : DoubleGapMs;
    localparam int          MS_W       = $clog2(MS_MAX + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        LONG   = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic               prev_q;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [MS_W-1:0]    ms_q, ms_d;
    logic               short_q, short_d;
    logic               long_q, long_d;
    logic               double_q, double_d;
    logic               hold_q, hold_d;

    logic rise, fall, ms_tick, long_exp, gap_exp;

    assign rise    = btn_level_i & ~prev_q;
    assign fall    = ~btn_level_i & prev_q;
    assign ms_tick = (presc_q == PRESC_W'(PRESC_MAX));

    // Expiry is taken on the tick that would carry the timer onto the limit,
    // so it lands exactly Ms*CYC_PER_MS cycles after entering the state.
    assign long_exp = ms_tick && (ms_q == MS_W'(LongPressMs - 1));
    assign gap_exp  = ms_tick && (ms_q == MS_W'(DoubleGapMs - 1));

    always_comb begin
        state_d  = state_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;

        // Edges are tested before expiries so an edge always wins a tie.
        unique case (state_q)
            IDLE: begin
                if (rise) state_d = PRESS1;
            end
            PRESS1: begin
                if (fall) begin
                    state_d = WAIT2;
                end else if (long_exp) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                end
            end
            WAIT2: begin
                if (rise) begin
                    state_d = PRESS2;
                end else if (gap_exp) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                end
            end
            PRESS2: begin
                if (fall) begin
                    state_d  = IDLE;
                    double_d = 1'b1;
                end else if (long_exp) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                end
            end
            LONG: begin
                if (fall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        hold_d = (state_d == LONG);
    end

    always_comb begin
        presc_d = presc_q;
        ms_d    = ms_q;
        if (state_d != state_q) begin
            presc_d = '0;
            ms_d    = '0;
        end else if (ms_tick) begin
            presc_d = '0;
            if (ms_q != MS_W'(MS_MAX)) ms_d = ms_q + MS_W'(1);
        end else begin
            presc_d = presc_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            prev_q   <= 1'b0;
            presc_q  <= '0;
            ms_q     <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            hold_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= btn_level_i;
            presc_q  <= presc_d;
            ms_q     <= ms_d;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
            hold_q   <= hold_d;
        end
    end

    assign short_press_o  = short_q;
    assign long_press_o   = long_q;
    assign double_press_o = double_q;
    assign hold_o         = hold_q;

endmodule

// File: tb/tb_button_press_decoder.sv
// Directed bench: cycle-count model of the press classifier compared every
// cycle, plus literal pulse counts and latencies per scenario.
module tb_button_press_decoder;

    localparam int CLK_FREQ = 10_000;
    localparam int LONG_MS  = 5;
    localparam int GAP_MS   = 3;
    localparam int NL       = LONG_MS * CLK_FREQ / 1000;  // 50 cycles
    localparam int NG       = GAP_MS * CLK_FREQ / 1000;   // 30 cycles

    logic clk = 1'b0;
    logic rst_n;
    logic btn;
    logic short_o, long_o, double_o, hold_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    button_press_decoder #(
        .ClkFreq    (CLK_FREQ),
        .LongPressMs(LONG_MS),
        .DoubleGapMs(GAP_MS)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .btn_level_i   (btn),
        .short_press_o (short_o),
        .long_press_o  (long_o),
        .double_press_o(double_o),
        .hold_o        (hold_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d at cyc %0d", name, act, exp, cyc);
        end
    endtask

    // Model phases: 0 idle, 1 first press, 2 gap, 3 second press, 4 held.
    // t counts clock edges since the phase was entered.
    int   m_phase, m_t;
    logic m_prev, m_short, m_long, m_double, m_hold;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_t <= 0; m_prev <= 1'b0;
            m_short <= 1'b0; m_long <= 1'b0; m_double <= 1'b0; m_hold <= 1'b0;
        end else begin : model_step
            int   ph, t;
            logic s, l, d, up, dn;
            ph = m_phase; t = m_t + 1; s = 1'b0; l = 1'b0; d = 1'b0;
            up = btn & ~m_prev;
            dn = ~btn & m_prev;
            case (m_phase)
                0: if (up) ph = 1;
                1: if (dn) ph = 2; else if (t == NL) begin ph = 4; l = 1'b1; end
                2: if (up) ph = 3; else if (t == NG) begin ph = 0; s = 1'b1; end
                3: if (dn) begin ph = 0; d = 1'b1; end
                   else if (t == NL) begin ph = 4; l = 1'b1; end
                4: if (dn) ph = 0;
                default: ph = 0;
            endcase
            if (ph != m_phase) t = 0;
            m_phase <= ph; m_t <= t; m_prev <= btn;
            m_short <= s; m_long <= l; m_double <= d; m_hold <= (ph == 4);
        end
    end

    // Per-cycle comparison, plus pulse counters and timestamps for the
    // literal checks in the stimulus.
    int n_short = 0, n_long = 0, n_double = 0;
    int t_short = -1, t_long = -1, t_double = -1;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", {short_o, long_o, double_o, hold_o}, 0);
        end else begin
            chk("outputs_vs_model", {short_o, long_o, double_o, hold_o},
                {m_short, m_long, m_double, m_hold});
        end
        if (short_o)  begin n_short++;  t_short  = cyc; end
        if (long_o)   begin n_long++;   t_long   = cyc; end
        if (double_o) begin n_double++; t_double = cyc; end
    end

    int b_s, b_l, b_d;
    int ev_cyc;

    // Drives the level for n cycles; ev_cyc is the edge that samples the change.
    task automatic drive(input logic v, input int n);
        btn    = v;
        ev_cyc = cyc + 1;
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        b_s = n_short; b_l = n_long; b_d = n_double;
    endtask

    task automatic counts(input string name, input int s, input int l, input int d);
        chk({name, "_short"},  n_short - b_s,  s);
        chk({name, "_long"},   n_long - b_l,   l);
        chk({name, "_double"}, n_double - b_d, d);
    endtask

    initial begin
        rst_n = 1'b0;
        btn   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 1: short press, pulse 30 edges after the fall is sampled
        snap();
        drive(1'b1, 20);
        drive(1'b0, 40);
        chk("t1_short_latency", t_short - ev_cyc, 30);
        counts("t1", 1, 0, 0);

        // 2: long press, pulse 50 edges after the rise is sampled
        snap();
        drive(1'b1, 55);
        chk("t2_long_latency", t_long - ev_cyc, 50);
        chk("t2_hold_mid", hold_o, 1);
        drive(1'b1, 25);
        drive(1'b0, 2);
        chk("t2_hold_released", hold_o, 0);
        drive(1'b0, 38);
        counts("t2", 0, 1, 0);

        // 3: double press, pulse on the edge sampling the second fall
        snap();
        drive(1'b1, 10);
        drive(1'b0, 10);
        drive(1'b1, 10);
        drive(1'b0, 40);
        chk("t3_double_latency", t_double - ev_cyc, 0);
        counts("t3", 0, 0, 1);

        // 4a: re-rise well inside the gap
        snap();
        drive(1'b1, 10); drive(1'b0, 29); drive(1'b1, 10); drive(1'b0, 40);
        counts("t4a", 0, 0, 1);

        // 4b: re-rise on the very edge the gap expires -> edge wins
        snap();
        drive(1'b1, 10); drive(1'b0, 30); drive(1'b1, 10); drive(1'b0, 40);
        counts("t4b", 0, 0, 1);

        // 4c: gap expired, second press classified on its own
        snap();
        drive(1'b1, 10); drive(1'b0, 31); drive(1'b1, 10); drive(1'b0, 40);
        counts("t4c", 2, 0, 0);

        // 5: long second press discards the pending double
        snap();
        drive(1'b1, 10); drive(1'b0, 10); drive(1'b1, 60); drive(1'b0, 10);
        counts("t5", 0, 1, 0);

        // 6: reset mid-press aborts silently, next press behaves normally
        snap();
        drive(1'b1, 15);
        rst_n = 1'b0;
        drive(1'b0, 3);
        rst_n = 1'b1;
        drive(1'b0, 40);
        counts("t6_abort", 0, 0, 0);
        snap();
        drive(1'b1, 20);
        drive(1'b0, 40);
        chk("t6_short_latency", t_short - ev_cyc, 30);
        counts("t6_after", 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
